code_conv_arbiter: RTL

//   Shares one 4-bit code-conversion datapath (BCD / Gray / Hamming(7,4)) among NREQ requesters.

---
 rtl/code_conv_arbiter_pkg.sv | 41 ++++
 rtl/code_conv_unit.sv | 39 +++
 rtl/code_conv_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/code_conv_arbiter_pkg.sv
// Shared definitions for the code-conversion arbiter: mode and FSM encodings, code width, converters.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package code_conv_arbiter_pkg;

  localparam int CODE_W = 7;

  typedef enum logic [1:0] {
    MODE_BCD  = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_HAM  = 2'd2,
    MODE_RSV  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Single BCD digit; values above 9 have no one-digit encoding and are flagged.
  function automatic logic [CODE_W:0] binary_2_bcd(input logic [3:0] d);
    logic bad;
    bad = (d > 4'd9);
    return bad ? {1'b1, {CODE_W{1'b0}}} : {1'b0, 3'b000, d};
  endfunction

  function automatic logic [CODE_W-1:0] binary_2_gray(input logic [3:0] d);
    return {3'b000, d ^ (d >> 1)};
  endfunction

  // Even-parity Hamming(7,4); bit 0 of the result is codeword position 1.
  function automatic logic [CODE_W-1:0] bin_2_hamming_pair(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

endpackage

// File: rtl/code_conv_unit.sv
// Combinational converter: selects BCD, Gray or Hamming(7,4) of a 4-bit operand by mode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module code_conv_unit
  import code_conv_arbiter_pkg::*;
(
  input  logic [3:0]        bn,
  input  logic [1:0]        mode,
  output logic [CODE_W-1:0] code,
  output logic              err
);

  logic [CODE_W:0]   bcd_res;
  logic [CODE_W-1:0] gray_res;
  logic [CODE_W-1:0] ham_res;

  assign bcd_res  = binary_2_bcd(bn);
  assign gray_res = binary_2_gray(bn);
  assign ham_res  = bin_2_hamming_pair(bn);

  // Mode mux; the reserved mode reports an error with an all-zero code.
  always_comb begin
    code = '0;
    err  = 1'b0;
    case (mode)
      MODE_BCD: begin
        code = bcd_res[CODE_W-1:0];
        err  = bcd_res[CODE_W];
      end
      MODE_GRAY: code = gray_res;
      MODE_HAM:  code = ham_res;
      default: begin
        code = '0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/code_conv_arbiter.sv
// Round-robin shares one code converter among NREQ requesters; result registered under valid/ready.
// Latency: grant the edge after req is sampled in IDLE, out_valid one edge later; 3 cycles minimum per result.
// Backpressure: result held stable while out_ready is low; no new grant until the held result is accepted.
module code_conv_arbiter
  import code_conv_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   bn_in,
  input  logic [2*NREQ-1:0]   mode_in,
  output logic [NREQ-1:0]     grant,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDW-1:0]      out_id,
  output logic [1:0]          out_mode,
  output logic [CODE_W-1:0]   out_code,
  output logic                err
);

  state_e state, state_nxt;

  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    lat_id;
  logic [3:0]        lat_bn;
  logic [1:0]        lat_mode;

  logic              pick_found;
  logic [IDW-1:0]    pick_id;
  logic [NREQ-1:0]   pick_onehot;
  int                cand;
  logic [NREQ-1:0]   cand_mask;

  logic [4*NREQ-1:0] bn_sh;
  logic [2*NREQ-1:0] mode_sh;

  logic [CODE_W-1:0] conv_code;
  logic              conv_err;

  // Round-robin search: first set request at or above rr_ptr, wrapping to 0.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = 0;
    cand_mask  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_mask = NREQ'(1) << cand;
      if (!pick_found && (|(req & cand_mask))) begin
        pick_found = 1'b1;
        pick_id    = IDW'(cand);
      end
    end
  end

  assign pick_onehot = NREQ'(1) << pick_id;
  assign bn_sh       = bn_in >> (4 * pick_id);
  assign mode_sh     = mode_in >> (2 * pick_id);

  code_conv_unit u_conv (
    .bn   (lat_bn),
    .mode (lat_mode),
    .code (conv_code),
    .err  (conv_err)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: one request per pass, and a held result must drain before re-arbitrating.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_found) state_nxt = ST_CONV;
      ST_CONV: state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, grant pulse, result registers and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant     <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_mode  <= '0;
      out_code  <= '0;
      err       <= 1'b0;
      rr_ptr    <= '0;
      lat_id    <= '0;
      lat_bn    <= '0;
      lat_mode  <= '0;
    end else begin
      grant <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant    <= pick_onehot;
            lat_id   <= pick_id;
            lat_bn   <= bn_sh[3:0];
            lat_mode <= mode_sh[1:0];
          end
        end
        ST_CONV: begin
          out_valid <= 1'b1;
          out_id    <= lat_id;
          out_mode  <= lat_mode;
          out_code  <= conv_code;
          err       <= conv_err;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rr_ptr    <= (lat_id == IDW'(NREQ - 1)) ? '0 : lat_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
